// File: rtl/lcd_bus_ctrl_if.sv
`timescale 1ns/1ps
// Host write port of lcd_bus_ctrl: a valid/ready handshake that carries
// one panel word together with its data/command flag.
interface lcd_bus_ctrl_if #(
    parameter int DW = 16
);
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          in_is_data;

    modport master (output in_valid, output in_data, output in_is_data, input in_ready);
    modport slave  (input in_valid, input in_data, input in_is_data, output in_ready);
endinterface

// File: rtl/lcd_bus_ctrl.sv
`timescale 1ns/1ps
// 8080-style parallel LCD write controller: panel hardware-reset sequencer,
// host write queue and a WR strobe generator with programmable phase lengths.
module lcd_bus_ctrl #(
    parameter int DW         = 16,
    parameter int FIFO_DEPTH = 8,
    parameter int T_SETUP    = 1,
    parameter int T_WRL      = 2,
    parameter int T_WRH      = 2,
    parameter int T_RST      = 10,
    parameter int T_RST_WAIT = 20
) (
    input  logic                          clk,
    input  logic                          reset,
    lcd_bus_ctrl_if.slave                 host,
    output logic [DW-1:0]                 lcd_data,
    output logic                          lcd_rs,
    output logic                          lcd_cs_n,
    output logic                          lcd_wr_n,
    output logic                          lcd_rd_n,
    output logic                          lcd_rst_n,
    output logic                          init_done,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int T_M1  = (T_RST > T_RST_WAIT) ? T_RST : T_RST_WAIT;
    localparam int T_M2  = (T_SETUP > T_WRL) ? T_SETUP : T_WRL;
    localparam int T_M3  = (T_M2 > T_WRH) ? T_M2 : T_WRH;
    localparam int T_MAX = (T_M1 > T_M3) ? T_M1 : T_M3;
    localparam int CW    = $clog2(T_MAX + 1);
    localparam logic [AW:0] DEPTH_L = FIFO_DEPTH[AW:0];

    typedef enum logic [2:0] {RST_HOLD, RST_WAIT, IDLE, SETUP, WR_LOW, WR_HIGH} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            pop;

    logic [DW:0]     mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q;
    logic            push, fifo_empty;

    logic [DW-1:0]   lcd_data_q, lcd_data_d;
    logic            lcd_rs_q, lcd_rs_d;
    logic            lcd_cs_n_q, lcd_cs_n_d;
    logic            lcd_wr_n_q, lcd_wr_n_d;
    logic            lcd_rst_n_q, lcd_rst_n_d;
    logic            init_done_q, init_done_d;

    // ready comes from the registered level, so a full queue refuses a push
    // even in a cycle where a pop frees a slot
    assign host.in_ready = (level_q < DEPTH_L);
    assign push          = host.in_valid && host.in_ready;
    assign fifo_empty    = (level_q == '0);

    // NOTE: the queue storage has no reset; the pointers and level define
    // which entries are valid, so stale contents are never observed.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= {host.in_is_data, host.in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            unique case ({push, pop})
                2'b10:   level_q <= level_q + (AW+1)'(1);
                2'b01:   level_q <= level_q - (AW+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    // State and all panel-facing outputs are registered together so the pins
    // change only on clock edges.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= RST_HOLD;
            cnt_q       <= '0;
            lcd_data_q  <= '0;
            lcd_rs_q    <= 1'b0;
            lcd_cs_n_q  <= 1'b1;
            lcd_wr_n_q  <= 1'b1;
            lcd_rst_n_q <= 1'b0;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lcd_data_q  <= lcd_data_d;
            lcd_rs_q    <= lcd_rs_d;
            lcd_cs_n_q  <= lcd_cs_n_d;
            lcd_wr_n_q  <= lcd_wr_n_d;
            lcd_rst_n_q <= lcd_rst_n_d;
            init_done_q <= init_done_d;
        end
    end

    // NOTE: every signal assigned in a combinational block gets a default
    // first, so no path through the case statement can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        pop     = 1'b0;
        unique case (state_q)
            RST_HOLD: if (cnt_q == CW'(T_RST - 1)) begin
                state_d = RST_WAIT;
                cnt_d   = '0;
            end
            RST_WAIT: if (cnt_q == CW'(T_RST_WAIT - 1)) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            IDLE: begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: if (cnt_q == CW'(T_SETUP - 1)) begin
                state_d = WR_LOW;
                cnt_d   = '0;
            end
            WR_LOW: if (cnt_q == CW'(T_WRL - 1)) begin
                state_d = WR_HIGH;
                cnt_d   = '0;
            end
            WR_HIGH: if (cnt_q == CW'(T_WRH - 1)) begin
                cnt_d = '0;
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = SETUP;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = RST_HOLD;
                cnt_d   = '0;
            end
        endcase
    end

    always_comb begin
        lcd_rst_n_d = (state_d != RST_HOLD);
        lcd_wr_n_d  = (state_d != WR_LOW);
        lcd_cs_n_d  = !(state_d inside {SETUP, WR_LOW, WR_HIGH});
        init_done_d = !(state_d inside {RST_HOLD, RST_WAIT});
        lcd_data_d  = lcd_data_q;
        lcd_rs_d    = lcd_rs_q;
        if (pop) begin
            {lcd_rs_d, lcd_data_d} = mem_q[rd_ptr_q];
        end
    end

    assign lcd_data   = lcd_data_q;
    assign lcd_rs     = lcd_rs_q;
    assign lcd_cs_n   = lcd_cs_n_q;
    assign lcd_wr_n   = lcd_wr_n_q;
    assign lcd_rd_n   = 1'b1;
    assign lcd_rst_n  = lcd_rst_n_q;
    assign init_done  = init_done_q;
    assign busy       = (state_q inside {SETUP, WR_LOW, WR_HIGH}) || !fifo_empty;
    assign fifo_level = level_q;
endmodule

// File: tb/tb_lcd_bus_ctrl.sv
`timescale 1ns/1ps
// Directed bench for lcd_bus_ctrl: default instance (a) plus an 8-bit instance
// with altered strobe timing (b); WR rising edges are logged per instance.
module tb_lcd_bus_ctrl;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic reset_a, reset_b;

    lcd_bus_ctrl_if #(.DW(16)) bus_a ();
    lcd_bus_ctrl_if #(.DW(8))  bus_b ();

    logic [15:0] a_data;
    logic        a_rs, a_cs_n, a_wr_n, a_rd_n, a_rst_n, a_init, a_busy;
    logic [3:0]  a_level;
    logic [7:0]  b_data;
    logic        b_rs, b_cs_n, b_wr_n, b_rd_n, b_rst_n, b_init, b_busy;
    logic [3:0]  b_level;

    lcd_bus_ctrl dut_a (
        .clk(clk), .reset(reset_a), .host(bus_a),
        .lcd_data(a_data), .lcd_rs(a_rs), .lcd_cs_n(a_cs_n), .lcd_wr_n(a_wr_n),
        .lcd_rd_n(a_rd_n), .lcd_rst_n(a_rst_n), .init_done(a_init),
        .busy(a_busy), .fifo_level(a_level)
    );

    lcd_bus_ctrl #(.DW(8), .T_SETUP(2), .T_WRL(1), .T_WRH(3)) dut_b (
        .clk(clk), .reset(reset_b), .host(bus_b),
        .lcd_data(b_data), .lcd_rs(b_rs), .lcd_cs_n(b_cs_n), .lcd_wr_n(b_wr_n),
        .lcd_rd_n(b_rd_n), .lcd_rst_n(b_rst_n), .init_done(b_init),
        .busy(b_busy), .fifo_level(b_level)
    );

    // WR rising-edge logs: the panel latches data on that edge
    logic        a_prev_wr = 1'b1, b_prev_wr = 1'b1;
    int          a_ev_cyc[$], b_ev_cyc[$];
    logic [15:0] a_ev_data[$];
    logic [7:0]  b_ev_data[$];
    logic        a_ev_rs[$], b_ev_rs[$];

    always @(negedge clk) begin
        if (!a_prev_wr && a_wr_n) begin
            a_ev_cyc.push_back(cyc);
            a_ev_data.push_back(a_data);
            a_ev_rs.push_back(a_rs);
        end
        a_prev_wr <= a_wr_n;
    end

    always @(negedge clk) begin
        if (!b_prev_wr && b_wr_n) begin
            b_ev_cyc.push_back(cyc);
            b_ev_data.push_back(b_data);
            b_ev_rs.push_back(b_rs);
        end
        b_prev_wr <= b_wr_n;
    end

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic clear_a();
        a_ev_cyc.delete();
        a_ev_data.delete();
        a_ev_rs.delete();
    endtask

    task automatic push_a(input logic [15:0] d, input logic isd);
        bus_a.in_valid   = 1'b1;
        bus_a.in_data    = d;
        bus_a.in_is_data = isd;
        tick();
        bus_a.in_valid   = 1'b0;
    endtask

    task automatic push_b(input logic [7:0] d, input logic isd);
        bus_b.in_valid   = 1'b1;
        bus_b.in_data    = d;
        bus_b.in_is_data = isd;
        tick();
        bus_b.in_valid   = 1'b0;
    endtask

    bit   exp_wr [7] = '{1, 1, 0, 0, 1, 1, 1};
    bit   exp_cs [7] = '{1, 0, 0, 0, 0, 0, 1};
    int   lows, highs, wr_lows, gaps, snap;
    bit   started, found;
    logic ready_seen [9];

    initial begin
        reset_a = 1'b0;
        reset_b = 1'b0;
        bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.in_is_data = 1'b0;
        bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.in_is_data = 1'b0;
        repeat (3) tick();

        // reset state
        check("rst_lcd_rst_n", a_rst_n, 0);
        check("rst_cs_n", a_cs_n, 1);
        check("rst_wr_n", a_wr_n, 1);
        check("rst_rd_n", a_rd_n, 1);
        check("rst_data", a_data, 0);
        check("rst_rs", a_rs, 0);
        check("rst_init_done", a_init, 0);
        check("rst_in_ready", bus_a.in_ready, 1);
        check("rst_level", a_level, 0);
        check("rst_busy", a_busy, 0);

        // panel reset sequence timing
        reset_a = 1'b1;
        lows = 0; highs = 0; wr_lows = 0;
        for (int i = 0; i < 100; i++) begin
            if (a_init) break;
            if (!a_rst_n) lows++;
            else highs++;
            if (!a_wr_n) wr_lows++;
            tick();
        end
        check("init_done_reached", a_init, 1);
        check("rst_low_cycles", lows, 10);
        check("rst_high_cycles", highs, 20);
        check("wr_during_init", wr_lows, 0);

        // single command write, cycle by cycle
        clear_a();
        push_a(16'h002C, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("cmd_wr_n[%0d]", i), a_wr_n, exp_wr[i]);
            check($sformatf("cmd_cs_n[%0d]", i), a_cs_n, exp_cs[i]);
            if (i == 3) begin
                check("cmd_data", a_data, 32'h002C);
                check("cmd_rs", a_rs, 0);
            end
            tick();
        end
        check("cmd_writes", a_ev_cyc.size(), 1);

        // three back-to-back data words
        clear_a();
        push_a(16'h1111, 1'b1);
        push_a(16'h2222, 1'b1);
        push_a(16'h3333, 1'b1);
        started = 1'b0; gaps = 0;
        for (int i = 0; i < 40 && a_ev_cyc.size() < 3; i++) begin
            if (!a_cs_n) started = 1'b1;
            else if (started) gaps++;
            tick();
        end
        check("burst_writes", a_ev_cyc.size(), 3);
        if (a_ev_cyc.size() == 3) begin
            check("burst_space01", a_ev_cyc[1] - a_ev_cyc[0], 5);
            check("burst_space12", a_ev_cyc[2] - a_ev_cyc[1], 5);
            check("burst_d0", a_ev_data[0], 32'h1111);
            check("burst_d1", a_ev_data[1], 32'h2222);
            check("burst_d2", a_ev_data[2], 32'h3333);
            check("burst_rs", {a_ev_rs[0], a_ev_rs[1], a_ev_rs[2]}, 3'b111);
        end
        check("burst_cs_gaps", gaps, 0);
        repeat (4) tick();
        check("burst_end_cs_n", a_cs_n, 1);
        check("burst_end_busy", a_busy, 0);

        // overfill the queue while the panel is held in reset
        reset_a = 1'b0;
        tick(); tick();
        reset_a = 1'b1;
        clear_a();
        for (int i = 0; i < 9; i++) begin
            ready_seen[i] = bus_a.in_ready;
            push_a(16'(16'hA000 + i), i[0]);
        end
        for (int i = 0; i < 9; i++)
            check($sformatf("fill_ready[%0d]", i), ready_seen[i], (i < 8) ? 1 : 0);
        check("fill_level", a_level, 8);
        check("fill_in_ready", bus_a.in_ready, 0);
        check("fill_during_rst_hold", a_rst_n, 0);
        check("fill_busy", a_busy, 1);
        for (int i = 0; i < 200 && a_ev_cyc.size() < 8; i++) tick();
        repeat (20) tick();
        check("fill_writes", a_ev_cyc.size(), 8);
        if (a_ev_cyc.size() == 8) begin
            for (int j = 0; j < 8; j++) begin
                check($sformatf("fill_d[%0d]", j), a_ev_data[j], 32'hA000 + j);
                check($sformatf("fill_rs[%0d]", j), a_ev_rs[j], j % 2);
            end
        end
        check("fill_level_drained", a_level, 0);

        // reset during WR_LOW with words still queued
        clear_a();
        for (int j = 0; j < 6; j++) push_a(16'(16'hB000 + j), 1'b1);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (!a_wr_n) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("abort_wr_low_found", found, 1);
        check("abort_level_before", a_level, 4);
        reset_a = 1'b0;
        tick();
        check("abort_wr_n", a_wr_n, 1);
        check("abort_cs_n", a_cs_n, 1);
        check("abort_level", a_level, 0);
        check("abort_lcd_rst_n", a_rst_n, 0);
        check("abort_init_done", a_init, 0);
        reset_a = 1'b1;
        tick();
        snap = a_ev_cyc.size();
        for (int i = 0; i < 100 && !a_init; i++) tick();
        check("abort_reinit", a_init, 1);
        repeat (10) tick();
        check("abort_no_writes", a_ev_cyc.size(), snap);
        check("abort_busy", a_busy, 0);

        // narrow bus with altered strobe timing
        check("b_rst_state", {b_rst_n, b_cs_n, b_wr_n, b_init}, 4'b0110);
        reset_b = 1'b1;
        for (int i = 0; i < 100 && !b_init; i++) tick();
        check("b_init_done", b_init, 1);
        push_b(8'h11, 1'b1);
        push_b(8'h22, 1'b1);
        push_b(8'h33, 1'b1);
        for (int i = 0; i < 60 && b_ev_cyc.size() < 3; i++) tick();
        check("b_writes", b_ev_cyc.size(), 3);
        if (b_ev_cyc.size() == 3) begin
            check("b_space01", b_ev_cyc[1] - b_ev_cyc[0], 6);
            check("b_space12", b_ev_cyc[2] - b_ev_cyc[1], 6);
            check("b_d0", b_ev_data[0], 32'h11);
            check("b_d1", b_ev_data[1], 32'h22);
            check("b_d2", b_ev_data[2], 32'h33);
            check("b_rs", {b_ev_rs[0], b_ev_rs[1], b_ev_rs[2]}, 3'b111);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog");
    end
endmodule
